sdm_pdm_dac: RTL

//  Parametrised 1-bit sigma-delta PDM DAC, successor to the fixed first-order SDM.

---
 rtl/sdm_pkg.sv | 35 +++
 rtl/sdm_loop.sv | 55 +++++
 rtl/sdm_pdm_dac.sv | 67 ++++++
 3 files changed

// File: rtl/sdm_pkg.sv
// Shared types and helpers for the sigma-delta PDM DAC: loop-mode encoding,
// integrator width, half-scale constant and a saturating clamp.
package sdm_pkg;

   typedef enum logic {
      MODE_1ST = 1'b0,
      MODE_2ND = 1'b1
   } mode_t;

   localparam int unsigned N_DEF     = 16;
   localparam int unsigned GUARD_DEF = 4;

   // Signed width of the 2nd-order integrators.
   function automatic int unsigned accw(input int unsigned n, input int unsigned guard);
      return n + guard;
   endfunction

   function automatic longint half(input int unsigned n);
      return 64'sd1 <<< (n - 1);
   endfunction

   localparam longint HALF = half(N_DEF);

   // Clamp a wide signed value into the signed w-bit range.
   function automatic longint sat(input longint v, input int unsigned w);
      longint mx;
      longint mn;
      mx = (64'sd1 <<< (w - 1)) - 64'sd1;
      mn = -mx - 64'sd1;
      if (v > mx) return mx;
      if (v < mn) return mn;
      return v;
   endfunction

endpackage

// File: rtl/sdm_loop.sv
// Noise-shaping loop: 1st-order carry accumulator or 2nd-order CIFB with
// saturating integrators. Produces one registered pdm bit per clock.
module sdm_loop
   import sdm_pkg::*;
#(
   parameter int unsigned N     = N_DEF,
   parameter int unsigned GUARD = GUARD_DEF
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         mode,
   input  logic [N-1:0] hold,
   output logic         pdm
);

   localparam int unsigned AW     = accw(N, GUARD);
   localparam longint      HALF_V = half(N);

   logic [N-1:0]          acc;
   logic signed [AW-1:0]  i1;
   logic signed [AW-1:0]  i2;
   logic [N:0]            sum1;
   logic                  y;
   longint                x;
   longint                fb;
   longint                i1_nxt;
   longint                i2_nxt;

   // Next-state arithmetic for both loop orders.
   always_comb begin
      sum1   = {1'b0, acc} + {1'b0, hold};
      y      = ~i2[AW-1];
      x      = $signed(64'(hold)) - HALF_V;
      fb     = y ? HALF_V : -HALF_V;
      i1_nxt = sat(64'(i1) + x - fb, AW);
      i2_nxt = sat(64'(i2) + 64'(i1) - fb, AW);
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         acc <= '0;
         i1  <= '0;
         i2  <= '0;
         pdm <= 1'b0;
      end else if (mode == MODE_2ND) begin
         i1  <= AW'(i1_nxt);
         i2  <= AW'(i2_nxt);
         pdm <= y;
      end else begin
         acc <= sum1[N-1:0];
         pdm <= sum1[N];
      end
   end

endmodule

// File: rtl/sdm_pdm_dac.sv
// 1-bit sigma-delta PDM DAC: OSR slot counter, valid/ready sample capture,
// underrun flag, and the selectable-order shaping loop.
module sdm_pdm_dac
   import sdm_pkg::*;
#(
   parameter int unsigned N     = N_DEF,
   parameter int unsigned OSR   = 2,
   parameter int unsigned GUARD = GUARD_DEF
) (
   input  logic         clk,
   input  logic         areset,
   input  logic         enable,
   input  logic         order2,
   input  logic [N-1:0] din,
   input  logic         din_valid,
   output logic         din_ready,
   output logic         pdm,
   output logic         underrun
);

   localparam int unsigned    CW   = (OSR > 1) ? $clog2(OSR) : 1;
   localparam logic [CW-1:0]  LAST = CW'(OSR - 1);

   logic [CW-1:0] cnt;
   logic [N-1:0]  hold;
   mode_t         mode;
   mode_t         mode_in;
   logic          cap;
   logic          clr;

   // A capture that switches loop order restarts the integrators from zero.
   always_comb begin
      cap     = din_ready & din_valid;
      mode_in = order2 ? MODE_2ND : MODE_1ST;
      clr     = areset | ~enable | (cap & (mode_in != mode));
   end

   always_ff @(posedge clk) begin
      if (areset || !enable) begin
         cnt       <= '0;
         hold      <= '0;
         mode      <= MODE_1ST;
         din_ready <= 1'b0;
         underrun  <= 1'b0;
      end else begin
         cnt       <= (cnt == LAST) ? '0 : cnt + CW'(1);
         din_ready <= (cnt == LAST);
         underrun  <= din_ready & ~din_valid;
         if (cap) begin
            hold <= din;
            mode <= mode_in;
         end
      end
   end

   sdm_loop #(
      .N     (N),
      .GUARD (GUARD)
   ) u_loop (
      .clk  (clk),
      .clr  (clr),
      .mode (mode),
      .hold (hold),
      .pdm  (pdm)
   );

endmodule
